dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer for the shared byte-addressed data memory (64 bytes, big-endian, 32-bit word access).
- Port A is the CPU load/store path; port B is the debug/loader path.
- Grants round-robin, checks each request, drives the memory's active-low RD/WR strobes for exactly one cycle, and returns registered read data plus a one-cycle valid pulse.

Parameters:
- ADDR_W, 32, address width of requester and memory ports.
- DATA_W, 32, data width.
- MEM_BYTES, 64, memory size in bytes; the highest legal word address is MEM_BYTES-4.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- Reset  in  1  asynchronous, active-low reset.
- a_req  in  1  port A request; held with command until a_gnt.
- a_we  in  1  port A: 1=write, 0=read.
- a_addr  in  ADDR_W  port A byte address.
- a_wdata  in  DATA_W  port A write data.
- a_gnt  out  1  port A grant pulse (1 cycle).
- a_valid  out  1  port A response pulse (1 cycle).
- a_err  out  1  port A error flag, qualified by a_valid.
- a_rdata  out  DATA_W  port A read data, qualified by a_valid.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_valid, b_err, b_rdata: same as port A, for port B.
- mem_addr  out  ADDR_W  memory byte address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rd_n  out  1  memory read strobe, active-low.
- mem_wr_n  out  1  memory write strobe, active-low; the memory writes on negedge CLK.
- mem_rdata  in  DATA_W  memory read data; valid while mem_rd_n=0.

Behaviour:
- Reset (async, Reset=0), all outputs take these values immediately:
  - gnt, valid, err = 0
  - rdata, mem_addr, mem_wdata = 0
  - mem_rd_n = mem_wr_n = 1
  - state = IDLE; last_grant = B, so A wins the first tie.
- Reset asserted mid-access: the strobes deassert at once and the in-flight access is dropped with no response. A write whose negedge has already passed stays committed.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE. One transaction takes 3 cycles; there is no back-to-back pipelining.
- IDLE:
  - At posedge, if any req is high, pick the winner and capture its we/addr/wdata into command registers.
  - Only one requester high: it wins.
  - Both high: the port not equal to last_grant wins, then last_grant updates.
  - Go to ACCESS.
- ACCESS (1 cycle):
  - The winner's gnt = 1 for this cycle only.
  - If the command is legal: mem_addr and mem_wdata are driven from the command registers, and exactly one strobe is low (mem_rd_n=0 for a read, mem_wr_n=0 for a write).
  - At the end of the cycle, mem_rdata is registered into the winner's rdata for a read; rdata is unchanged for a write.
- RESP (1 cycle):
  - The winner's valid = 1; err reflects the check result. Both strobes = 1.
  - Return to IDLE. A req that stayed high is re-arbitrated in IDLE and granted in the next ACCESS cycle.
- Legality check at capture:
  - A command is illegal if addr[1:0] != 0 or addr > MEM_BYTES-4.
  - Illegal command: both strobes stay 1 for the whole transaction, the memory is untouched, rdata = 0, err = 1 in RESP.
  - Addresses do not wrap.
- Requester rules:
  - req and the command may drop in the cycle after gnt.
  - A req raised or dropped during ACCESS or RESP is only sampled in IDLE.
  - The non-winning port's gnt, valid and err stay 0.
- All outputs are registered.
- Strobes are never both low. mem_addr and mem_wdata hold their last value outside ACCESS.
- The arbiter adds no byte-lane or endianness logic; the memory packs bytes big-endian.

Decomposition:
- Shared package dmem_pkg holds:
  - FSM state enum (IDLE, ACCESS, RESP).
  - Port-select constants PORT_A and PORT_B.
  - MEM_BYTES.
  - A function addr_ok(addr) returning the legality result.
- One natural sub-module: rr_arbiter2, combinational 2-way round-robin selection taking req_a, req_b and last_grant, returning grant_a and grant_b.

Test Plan:
- A write, then A read:
  - A writes addr 0x08, data 0xDEADBEEF -> a_gnt in cycle 1 and mem_wr_n=0 in cycle 1; a_valid with a_err=0 in cycle 2.
  - A then reads 0x08 -> a_rdata=0xDEADBEEF.
- Simultaneous requests after reset:
  - A and B both read 0x00 -> A is granted first and B next; b_valid arrives 3 cycles after a_valid. A is never granted twice in a row while B requests.
- Misaligned / out-of-range:
  - A reads 0x06 -> strobes stay 1 throughout; a_valid=1, a_err=1, a_rdata=0.
  - B writes 0x3E -> b_err=1 and memory unchanged (a later read of 0x3C returns the old value).
- Sustained contention:
  - A and B held high for 12 cycles -> grants alternate A, B, A, B.
  - Each grant is exactly 1 cycle wide, and no strobe is ever low for more than 1 cycle.
- Reset mid-operation:
  - Assert Reset during ACCESS of a B read -> mem_rd_n=1 and b_gnt=0 immediately; no b_valid after release.
  - The next tie is won by A.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM states, port
// selectors, memory geometry and the command legality check.
package dmem_pkg;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned MEM_BYTES = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  // Word-aligned and fully inside the memory; addresses never wrap.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
    return (addr[1:0] == 2'b00) && (addr <= ADDR_W'(MEM_BYTES - 4));
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin pick: on a tie the port that did not win
// last time is chosen.
module rr_arbiter2
  import dmem_pkg::*;
(
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic last_grant_i,
  output logic grant_a_c_o,
  output logic grant_b_c_o
);

  assign grant_a_c_o = req_a_i & (~req_b_i | (last_grant_i == PORT_B));
  assign grant_b_c_o = req_b_i & ~grant_a_c_o;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the shared 64-byte data memory: round-robin
// grant, legality check, one-cycle active-low strobes, registered response.
module dmem_arbiter
  import dmem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req_i,
  input  logic              a_we_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  output logic              a_gnt_o,
  output logic              a_valid_o,
  output logic              a_err_o,
  output logic [DATA_W-1:0] a_rdata_o,
  input  logic              b_req_i,
  input  logic              b_we_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_wdata_i,
  output logic              b_gnt_o,
  output logic              b_valid_o,
  output logic              b_err_o,
  output logic [DATA_W-1:0] b_rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_rd_n_o,
  output logic              mem_wr_n_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              sel_q, sel_d;
  logic              ok_q, ok_d;
  cmd_t              cmd_q, cmd_d;
  logic              a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic              a_valid_q, a_valid_d, b_valid_q, b_valid_d;
  logic              a_err_q, a_err_d, b_err_q, b_err_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_rd_n_q, mem_rd_n_d, mem_wr_n_q, mem_wr_n_d;
  logic [DATA_W-1:0] resp_rdata;

  logic grant_a_c, grant_b_c;
  cmd_t cmd_a, cmd_b;

  assign cmd_a = {a_we_i, a_addr_i, a_wdata_i};
  assign cmd_b = {b_we_i, b_addr_i, b_wdata_i};

  rr_arbiter2 u_rr (
    .req_a_i      (a_req_i),
    .req_b_i      (b_req_i),
    .last_grant_i (last_q),
    .grant_a_c_o  (grant_a_c),
    .grant_b_c_o  (grant_b_c)
  );

  // Read data returned in RESP: zero for a rejected command, memory data for
  // a legal read, previous value for a legal write.
  always_comb begin
    resp_rdata = (sel_q == PORT_A) ? a_rdata_q : b_rdata_q;
    if (!ok_q) begin
      resp_rdata = '0;
    end else if (!cmd_q.we) begin
      resp_rdata = mem_rdata_i;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    sel_d       = sel_q;
    ok_d        = ok_q;
    cmd_d       = cmd_q;
    a_gnt_d     = 1'b0;
    b_gnt_d     = 1'b0;
    a_valid_d   = 1'b0;
    b_valid_d   = 1'b0;
    a_err_d     = 1'b0;
    b_err_d     = 1'b0;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rd_n_d  = 1'b1;
    mem_wr_n_d  = 1'b1;

    case (state_q)
      IDLE: begin
        if (grant_a_c || grant_b_c) begin
          sel_d   = grant_a_c ? PORT_A : PORT_B;
          last_d  = sel_d;
          cmd_d   = grant_a_c ? cmd_a : cmd_b;
          ok_d    = addr_ok(cmd_d.addr);
          a_gnt_d = grant_a_c;
          b_gnt_d = grant_b_c;
          state_d = ACCESS;
          if (ok_d) begin
            mem_addr_d  = cmd_d.addr;
            mem_wdata_d = cmd_d.wdata;
            mem_rd_n_d  = cmd_d.we;
            mem_wr_n_d  = ~cmd_d.we;
          end
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (sel_q == PORT_A) begin
          a_valid_d = 1'b1;
          a_err_d   = ~ok_q;
          a_rdata_d = resp_rdata;
        end else begin
          b_valid_d = 1'b1;
          b_err_d   = ~ok_q;
          b_rdata_d = resp_rdata;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= PORT_B;
      sel_q       <= PORT_A;
      ok_q        <= 1'b0;
      cmd_q       <= '0;
      a_gnt_q     <= 1'b0;
      b_gnt_q     <= 1'b0;
      a_valid_q   <= 1'b0;
      b_valid_q   <= 1'b0;
      a_err_q     <= 1'b0;
      b_err_q     <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_n_q  <= 1'b1;
      mem_wr_n_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      sel_q       <= sel_d;
      ok_q        <= ok_d;
      cmd_q       <= cmd_d;
      a_gnt_q     <= a_gnt_d;
      b_gnt_q     <= b_gnt_d;
      a_valid_q   <= a_valid_d;
      b_valid_q   <= b_valid_d;
      a_err_q     <= a_err_d;
      b_err_q     <= b_err_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_n_q  <= mem_rd_n_d;
      mem_wr_n_q  <= mem_wr_n_d;
    end
  end

  assign a_gnt_o     = a_gnt_q;
  assign b_gnt_o     = b_gnt_q;
  assign a_valid_o   = a_valid_q;
  assign b_valid_o   = b_valid_q;
  assign a_err_o     = a_err_q;
  assign b_err_o     = b_err_q;
  assign a_rdata_o   = a_rdata_q;
  assign b_rdata_o   = b_rdata_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_rd_n_o  = mem_rd_n_q;
  assign mem_wr_n_o  = mem_wr_n_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a transaction-level model predicts every output each
// cycle; directed scenarios pin the model with hand-computed values.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [31:0] a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0;
  logic        a_gnt, a_valid, a_err, b_gnt, b_valid, b_err;
  logic [31:0] a_rdata, b_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd_n, mem_wr_n;

  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .a_gnt_o(a_gnt), .a_valid_o(a_valid), .a_err_o(a_err), .a_rdata_o(a_rdata),
    .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .b_gnt_o(b_gnt), .b_valid_o(b_valid), .b_err_o(b_err), .b_rdata_o(b_rdata),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rd_n_o(mem_rd_n), .mem_wr_n_o(mem_wr_n), .mem_rdata_i(mem_rdata)
  );

  // Memory device: big-endian bytes, writes on negedge, junk when not read.
  logic [7:0] mem [MEM_BYTES];
  assign mem_rdata = (!mem_rd_n && mem_addr <= 32'd60)
    ? {mem[mem_addr[5:0]], mem[mem_addr[5:0] + 6'd1], mem[mem_addr[5:0] + 6'd2], mem[mem_addr[5:0] + 6'd3]}
    : 32'hBAD0_BAD0;
  always @(negedge clk) begin
    if (rst_n && !mem_wr_n && mem_addr <= 32'd60) begin
      mem[mem_addr[5:0]]        <= mem_wdata[31:24];
      mem[mem_addr[5:0] + 6'd1] <= mem_wdata[23:16];
      mem[mem_addr[5:0] + 6'd2] <= mem_wdata[15:8];
      mem[mem_addr[5:0] + 6'd3] <= mem_wdata[7:0];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic a_gnt, b_gnt, a_valid, b_valid, a_err, b_err, rd_n, wr_n;
    logic [31:0] a_rdata, b_rdata, maddr, mwdata;
  } exp_t;

  exp_t        cur;
  logic [7:0]  ref_mem [MEM_BYTES];
  int          busy;
  logic        mlast;
  logic        p_on, p_port, p_err, p_upd;
  logic [31:0] p_rdata;
  logic        m_win, m_we, m_ok;
  logic [31:0] m_ad, m_wd;

  function automatic logic [31:0] ref_word(input logic [31:0] ad);
    int i;
    i = int'(ad);
    return {ref_mem[i], ref_mem[i+1], ref_mem[i+2], ref_mem[i+3]};
  endfunction

  task automatic model_reset();
    cur = '{a_gnt: 1'b0, b_gnt: 1'b0, a_valid: 1'b0, b_valid: 1'b0, a_err: 1'b0, b_err: 1'b0,
            rd_n: 1'b1, wr_n: 1'b1, a_rdata: 32'h0, b_rdata: 32'h0, maddr: 32'h0, mwdata: 32'h0};
    busy  = 0;
    mlast = 1'b1;
    p_on  = 1'b0;
  endtask

  initial begin
    model_reset();
    forever begin
      exp_t n;
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        n = cur;
        n.a_gnt = 1'b0; n.b_gnt = 1'b0; n.a_valid = 1'b0; n.b_valid = 1'b0;
        n.a_err = 1'b0; n.b_err = 1'b0; n.rd_n = 1'b1; n.wr_n = 1'b1;
        if (p_on) begin
          if (!p_port) begin
            n.a_valid = 1'b1; n.a_err = p_err;
            if (p_upd) n.a_rdata = p_rdata;
          end else begin
            n.b_valid = 1'b1; n.b_err = p_err;
            if (p_upd) n.b_rdata = p_rdata;
          end
          p_on = 1'b0;
        end
        if (busy > 0) begin
          busy--;
        end else if (a_req || b_req) begin
          m_win = (a_req && b_req) ? ~mlast : b_req;
          mlast = m_win;
          m_we  = m_win ? b_we : a_we;
          m_ad  = m_win ? b_addr : a_addr;
          m_wd  = m_win ? b_wdata : a_wdata;
          m_ok  = (m_ad % 4 == 0) && (m_ad <= MEM_BYTES - 4);
          if (m_win) n.b_gnt = 1'b1; else n.a_gnt = 1'b1;
          if (m_ok) begin
            n.maddr = m_ad; n.mwdata = m_wd;
            if (m_we) n.wr_n = 1'b0; else n.rd_n = 1'b0;
          end
          p_on    = 1'b1;
          p_port  = m_win;
          p_err   = ~m_ok;
          p_upd   = ~m_ok | ~m_we;
          p_rdata = (m_ok && !m_we) ? ref_word(m_ad) : 32'h0;
          busy    = 2;
        end
        cur = n;
      end
    end
  end

  // Model memory commits a write at the negedge inside the strobe cycle.
  initial forever begin
    @(negedge clk);
    if (rst_n && !cur.wr_n) begin
      ref_mem[int'(cur.maddr)]     = cur.mwdata[31:24];
      ref_mem[int'(cur.maddr) + 1] = cur.mwdata[23:16];
      ref_mem[int'(cur.maddr) + 2] = cur.mwdata[15:8];
      ref_mem[int'(cur.maddr) + 3] = cur.mwdata[7:0];
    end
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("a_gnt", 32'(a_gnt), 32'(cur.a_gnt));
      chk("b_gnt", 32'(b_gnt), 32'(cur.b_gnt));
      chk("a_valid", 32'(a_valid), 32'(cur.a_valid));
      chk("b_valid", 32'(b_valid), 32'(cur.b_valid));
      chk("a_err", 32'(a_err), 32'(cur.a_err));
      chk("b_err", 32'(b_err), 32'(cur.b_err));
      chk("mem_rd_n", 32'(mem_rd_n), 32'(cur.rd_n));
      chk("mem_wr_n", 32'(mem_wr_n), 32'(cur.wr_n));
      chk("a_rdata", a_rdata, cur.a_rdata);
      chk("b_rdata", b_rdata, cur.b_rdata);
      chk("mem_addr", mem_addr, cur.maddr);
      chk("mem_wdata", mem_wdata, cur.mwdata);
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic port, input logic we, input logic [31:0] ad,
                       input logic [31:0] wd, output logic [31:0] rd,
                       output logic err, output logic [1:0] strb);
    logic got;
    got = 1'b0;
    strb = 2'b11;
    @(posedge clk); #1;
    if (!port) begin a_req = 1'b1; a_we = we; a_addr = ad; a_wdata = wd; end
    else begin b_req = 1'b1; b_we = we; b_addr = ad; b_wdata = wd; end
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got  = port ? b_gnt : a_gnt;
      strb = {mem_rd_n, mem_wr_n};
    end
    chk("gnt_timeout", 32'(got), 32'd1);
    @(posedge clk); #1;
    if (!port) a_req = 1'b0; else b_req = 1'b0;
    @(negedge clk);
    chk("resp_valid", 32'(port ? b_valid : a_valid), 32'd1);
    rd  = port ? b_rdata : a_rdata;
    err = port ? b_err : a_err;
  endtask

  task automatic rand_cmd(output logic we, output logic [31:0] ad, output logic [31:0] wd);
    int r;
    r  = int'($urandom_range(7));
    we = 1'($urandom_range(1));
    wd = $urandom;
    if (r <= 4)      ad = 32'(4 * $urandom_range(15));
    else if (r == 5) ad = 32'($urandom_range(71));
    else if (r == 6) ad = ($urandom_range(1) == 1) ? 32'hFFFF_FFFC : 32'd64;
    else             ad = 32'(60 + $urandom_range(3));
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  logic [31:0] rd;
  logic        err, got, ag, bg, bv;
  logic [1:0]  strb;
  logic        gseq [8];
  int          nseq, ta, tb;

  initial begin
    for (int i = 0; i < int'(MEM_BYTES); i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_gnt", 32'(a_gnt), 32'd0);
    chk("rst_b_valid", 32'(b_valid), 32'd0);
    chk("rst_rd_n", 32'(mem_rd_n), 32'd1);
    chk("rst_wr_n", 32'(mem_wr_n), 32'd1);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_a_rdata", a_rdata, 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    issue(1'b0, 1'b1, 32'h08, 32'hDEADBEEF, rd, err, strb);
    chk("a_wr_err", 32'(err), 32'd0);
    chk("a_wr_strobe", 32'(strb), 32'b10);
    issue(1'b0, 1'b0, 32'h08, 32'h0, rd, err, strb);
    chk("a_rd_data", rd, 32'hDEADBEEF);
    chk("a_rd_strobe", 32'(strb), 32'b01);
    issue(1'b0, 1'b0, 32'h06, 32'h0, rd, err, strb);
    chk("a_mis_err", 32'(err), 32'd1);
    chk("a_mis_rdata", rd, 32'd0);
    chk("a_mis_strobe", 32'(strb), 32'b11);
    issue(1'b0, 1'b1, 32'h3C, 32'h12345678, rd, err, strb);
    issue(1'b1, 1'b1, 32'h3E, 32'hFFFF_FFFF, rd, err, strb);
    chk("b_oor_err", 32'(err), 32'd1);
    issue(1'b1, 1'b0, 32'h3C, 32'h0, rd, err, strb);
    chk("b_rd_after_oor", rd, 32'h12345678);
    chk("b_rd_err", 32'(err), 32'd0);
    issue(1'b1, 1'b0, 32'h40, 32'h0, rd, err, strb);
    chk("b_0x40_err", 32'(err), 32'd1);

    // Tie right after reset, held for 12 cycles: grants A, B, A, B.
    pulse_reset();
    @(posedge clk); #1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h0;
    b_req = 1'b1; b_we = 1'b0; b_addr = 32'h0;
    nseq = 0; ta = -1; tb = -1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (a_gnt && nseq < 8) begin gseq[nseq] = 1'b0; nseq++; end
      if (b_gnt && nseq < 8) begin gseq[nseq] = 1'b1; nseq++; end
      if (a_valid && ta < 0) ta = c;
      if (b_valid && tb < 0) tb = c;
    end
    @(posedge clk); #1;
    a_req = 1'b0; b_req = 1'b0;
    chk("tie_count", 32'(nseq), 32'd4);
    chk("tie_g0", 32'(gseq[0]), 32'd0);
    chk("tie_g1", 32'(gseq[1]), 32'd1);
    chk("tie_g2", 32'(gseq[2]), 32'd0);
    chk("tie_g3", 32'(gseq[3]), 32'd1);
    chk("tie_valid_gap", 32'(tb - ta), 32'd3);
    repeat (4) @(posedge clk);

    // Reset during the ACCESS cycle of a B read.
    #1;
    b_req = 1'b1; b_we = 1'b0; b_addr = 32'h10;
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      got = b_gnt;
    end
    chk("mid_b_gnt_seen", 32'(got), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rd_n", 32'(mem_rd_n), 32'd1);
    chk("mid_rst_b_gnt", 32'(b_gnt), 32'd0);
    b_req = 1'b0;
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    bv = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (b_valid) bv = 1'b1;
    end
    chk("mid_no_b_valid", 32'(bv), 32'd0);
    @(posedge clk); #1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h20;
    b_req = 1'b1; b_we = 1'b0; b_addr = 32'h20;
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      got = a_gnt | b_gnt;
      ag  = a_gnt;
    end
    chk("post_rst_tie_a", 32'(ag), 32'd1);
    @(posedge clk); #1;
    a_req = 1'b0; b_req = 1'b0;
    repeat (4) @(posedge clk);

    // Randomised traffic on both ports.
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      ag = a_gnt; bg = b_gnt;
      @(posedge clk); #1;
      if (a_req) begin
        if (ag) begin
          if ($urandom_range(3) == 0) rand_cmd(a_we, a_addr, a_wdata);
          else a_req = 1'b0;
        end
      end else if ($urandom_range(2) == 0) begin
        a_req = 1'b1;
        rand_cmd(a_we, a_addr, a_wdata);
      end
      if (b_req) begin
        if (bg) begin
          if ($urandom_range(3) == 0) rand_cmd(b_we, b_addr, b_wdata);
          else b_req = 1'b0;
        end
      end else if ($urandom_range(2) == 0) begin
        b_req = 1'b1;
        rand_cmd(b_we, b_addr, b_wdata);
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
